// File: rtl/crypto_wallet_pio_pkg.sv
// Shared constants for the crypto_wallet GPIO controller: register map,
// edge-polarity encoding, width limit and the per-bit edge-event helper.
package crypto_wallet_pio_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLR   = 3'd5;
  localparam logic [2:0] REG_EDGE_SEL = 3'd6;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  localparam int MAX_WIDTH = 32;

  function automatic logic edge_event(input logic cond, input logic prev, input logic sel);
    return (sel == EDGE_FALL) ? (~cond & prev) : (cond & ~prev);
  endfunction

endpackage

// File: rtl/crypto_wallet_pio_in_cond.sv
// One GPIO input bit: SYNC_STAGES-deep synchroniser, followed by a
// stability filter when CRYPTO_WALLET_PIO_DEBOUNCE_EN is defined.
module crypto_wallet_pio_in_cond #(
  parameter int SYNC_STAGES = 2
`ifdef CRYPTO_WALLET_PIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 1000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  output logic cond_out
);

  logic [SYNC_STAGES-1:0] sync_r;

  // synchroniser shift chain, oldest sample at the top bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
    end
  end

`ifdef CRYPTO_WALLET_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic             filt_r;

  // filtered bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= 1'b0;
    end else if (sync_r[SYNC_STAGES-1] == filt_r) begin
      cnt_r  <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= sync_r[SYNC_STAGES-1];
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
    end
  end

  assign cond_out = filt_r;
`else
  assign cond_out = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/crypto_wallet_pio_gpio_ext.sv
// Avalon-MM GPIO controller: direction, atomic set/clear, edge capture, masked irq.
// Optional input debounce is compiled in with CRYPTO_WALLET_PIO_DEBOUNCE_EN.
module crypto_wallet_pio_gpio_ext
  import crypto_wallet_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  logic [WIDTH-1:0] data_out_r, dir_r, irq_mask_r, edge_cap_r, edge_sel_r, prev_r;
  logic [WIDTH-1:0] data_out_nxt_s, dir_nxt_s, irq_mask_nxt_s, edge_cap_nxt_s, edge_sel_nxt_s;
  logic [WIDTH-1:0] cond_s, event_s, w1c_s, wdata_s;
  logic [31:0]      readdata_r, rd_s;
  logic             irq_r, wr_s;

  assign wr_s    = chipselect & ~write_n;
  assign wdata_s = writedata[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bidir_port[i] = dir_r[i] ? data_out_r[i] : 1'bz;

    crypto_wallet_pio_in_cond #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef CRYPTO_WALLET_PIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_in_cond (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_in   (bidir_port[i]),
      .cond_out (cond_s[i])
    );
  end

  // register write decode and edge-capture next state
  always_comb begin
    data_out_nxt_s = data_out_r;
    dir_nxt_s      = dir_r;
    irq_mask_nxt_s = irq_mask_r;
    edge_sel_nxt_s = edge_sel_r;
    w1c_s          = {WIDTH{1'b0}};
    event_s        = {WIDTH{1'b0}};
    if (wr_s) begin
      case (address)
        REG_DATA:     data_out_nxt_s = wdata_s;
        REG_DIR:      dir_nxt_s      = wdata_s;
        REG_IRQ_MASK: irq_mask_nxt_s = wdata_s;
        REG_EDGE_CAP: w1c_s          = wdata_s;
        REG_OUTSET:   data_out_nxt_s = data_out_r | wdata_s;
        REG_OUTCLR:   data_out_nxt_s = data_out_r & ~wdata_s;
        REG_EDGE_SEL: edge_sel_nxt_s = wdata_s;
        default:      w1c_s          = {WIDTH{1'b0}};
      endcase
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
    for (int i = 0; i < WIDTH; i++) begin
      event_s[i] = edge_event(cond_s[i], prev_r[i], edge_sel_r[i]);
    end
    // a new event wins over a simultaneous write-1-to-clear
    edge_cap_nxt_s = (edge_cap_r & ~w1c_s) | event_s;
  end

  // read mux; upper bits beyond WIDTH stay zero
  always_comb begin
    rd_s = 32'd0;
    case (address)
      REG_DATA:     rd_s[WIDTH-1:0] = cond_s;
      REG_DIR:      rd_s[WIDTH-1:0] = dir_r;
      REG_IRQ_MASK: rd_s[WIDTH-1:0] = irq_mask_r;
      REG_EDGE_CAP: rd_s[WIDTH-1:0] = edge_cap_r;
      REG_EDGE_SEL: rd_s[WIDTH-1:0] = edge_sel_r;
      default:      rd_s            = 32'd0;
    endcase
  end

  // state registers, read data and interrupt output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= {WIDTH{1'b0}};
      dir_r      <= {WIDTH{1'b0}};
      irq_mask_r <= {WIDTH{1'b0}};
      edge_cap_r <= {WIDTH{1'b0}};
      edge_sel_r <= {WIDTH{1'b0}};
      prev_r     <= {WIDTH{1'b0}};
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      data_out_r <= data_out_nxt_s;
      dir_r      <= dir_nxt_s;
      irq_mask_r <= irq_mask_nxt_s;
      edge_cap_r <= edge_cap_nxt_s;
      edge_sel_r <= edge_sel_nxt_s;
      prev_r     <= cond_s;
      readdata_r <= rd_s;
      irq_r      <= |(edge_cap_r & irq_mask_r);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_crypto_wallet_pio_gpio_ext.sv
// Self-checking bench for crypto_wallet_pio_gpio_ext: table vectors, latency
// sequences and randomized register/pin traffic against a transaction-level model.
module tb_crypto_wallet_pio_gpio_ext;

  localparam int SS = 2;
`ifdef CRYPTO_WALLET_PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int LAT    = SS - 1 + DB;
  localparam int SETTLE = LAT + 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  wire  [31:0] readdata;
  wire         irq;
  wire  [31:0] bidir_port;
  logic [31:0] ext_val, ext_en;

  for (genvar gi = 0; gi < 32; gi++) begin : g_ext
    assign bidir_port[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  crypto_wallet_pio_gpio_ext #(
    .WIDTH(32), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .bidir_port(bidir_port)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // transaction-level model state
  logic [31:0] m_dout, m_dir, m_mask, m_cap, m_sel, m_ext;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [31:0] pin_exp;
    logic [31:0] pin_msk;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] eff();
    return (m_dir & m_dout) | (~m_dir & m_ext);
  endfunction

  function automatic logic [31:0] edges(input logic [31:0] o, input logic [31:0] n);
    return (~m_sel & ~o & n) | (m_sel & o & ~n);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return eff();
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      3'd6:    return m_sel;
      default: return 32'd0;
    endcase
  endfunction

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] old_e, chg;
    old_e = eff();
    @(negedge clk);
    if (a == 3'd1) begin
      // bits changing direction: bench drives the same value the DUT drives, no Z gap
      chg     = m_dir ^ d;
      m_ext   = (m_ext & ~chg) | (m_dout & chg);
      ext_val = m_ext;
      ext_en  = ~(m_dir & d);
    end
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    case (a)
      3'd0: m_dout = d;
      3'd1: m_dir  = d;
      3'd2: m_mask = d;
      3'd3: m_cap  = m_cap & ~d;
      3'd4: m_dout = m_dout | d;
      3'd5: m_dout = m_dout & ~d;
      3'd6: m_sel  = d;
      default: ;
    endcase
    ext_en = ~m_dir;
    m_cap  = m_cap | edges(old_e, eff());
    settle();
  endtask

  task automatic set_ext(input logic [31:0] v);
    logic [31:0] old_e;
    old_e = eff();
    @(negedge clk);
    m_ext = v; ext_val = v;
    m_cap = m_cap | edges(old_e, eff());
    settle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  ra;
    logic [2:0]  rlist[6];
    rlist = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    tbl[0]  = '{1'b1, 3'd1, 32'h0000_00FF, 32'h0, 32'h0000_0000, 32'h1FF};
    tbl[1]  = '{1'b0, 3'd1, 32'h0,         32'h0000_00FF, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 3'd0, 32'h0000_00A5, 32'h0, 32'h0000_00A5, 32'h1FF};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,         32'h0000_00A5, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'd3, 32'h0,         32'h0000_00A5, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'd4, 32'h0000_0100, 32'h0, 32'h0000_00A5, 32'h1FF};
    tbl[6]  = '{1'b1, 3'd1, 32'h0000_01FF, 32'h0, 32'h0000_01A5, 32'h1FF};
    tbl[7]  = '{1'b0, 3'd0, 32'h0,         32'h0000_01A5, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 3'd5, 32'h0000_0005, 32'h0, 32'h0000_01A0, 32'h1FF};
    tbl[9]  = '{1'b0, 3'd0, 32'h0,         32'h0000_01A0, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 3'd3, 32'h0,         32'h0000_01A5, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 3'd3, 32'h0,         32'h0000_0000, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    tbl[14] = '{1'b0, 3'd2, 32'h0,         32'hDEAD_BEEF, 32'h0, 32'h0};
    tbl[15] = '{1'b1, 3'd6, 32'h0000_0010, 32'h0, 32'h0, 32'h0};
    tbl[16] = '{1'b0, 3'd6, 32'h0,         32'h0000_0010, 32'h0, 32'h0};
    tbl[17] = '{1'b1, 3'd7, 32'h0000_1234, 32'h0, 32'h0, 32'h0};
    tbl[18] = '{1'b0, 3'd7, 32'h0,         32'h0000_0000, 32'h0, 32'h0};
    tbl[19] = '{1'b0, 3'd1, 32'h0,         32'h0000_01FF, 32'h0, 32'h0};
    tbl[20] = '{1'b1, 3'd2, 32'h0000_0000, 32'h0, 32'h0, 32'h0};
    tbl[21] = '{1'b1, 3'd1, 32'h0000_0000, 32'h0, 32'h0000_01A0, 32'h1FF};
    tbl[22] = '{1'b0, 3'd0, 32'h0,         32'h0000_01A0, 32'h0, 32'h0};
    tbl[23] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    ext_val = 32'd0; ext_en = 32'hFFFF_FFFF;
    m_dout = 32'd0; m_dir = 32'd0; m_mask = 32'd0; m_cap = 32'd0; m_sel = 32'd0; m_ext = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    settle();
    bus_read(3'd1, rd);
    check("reset_dir", rd, 32'd0);

    // table-driven register and pin vectors
    for (int i = 0; i < 24; i++) begin
      if (tbl[i].is_wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
        if (tbl[i].pin_msk != 32'd0)
          check($sformatf("tbl%0d_pins", i), bidir_port & tbl[i].pin_msk, tbl[i].pin_exp);
      end else begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_read", i), rd, tbl[i].exp);
      end
    end
    check("tbl_model_cap", m_cap, 32'd0);

    // rising-edge latency on pin 3
    set_ext(32'd0);
    bus_write(3'd6, 32'd0);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd2, 32'h0000_0008);
    @(negedge clk); address = 3'd0;
    @(negedge clk); ext_val[3] = 1'b1; m_ext[3] = 1'b1;
    for (int j = 0; j <= LAT + 3; j++) begin
      @(negedge clk);
      check($sformatf("lat_data_j%0d", j), {31'd0, readdata[3]}, (j >= LAT + 1) ? 32'd1 : 32'd0);
      check($sformatf("lat_irq_j%0d", j), {31'd0, irq}, (j >= LAT + 2) ? 32'd1 : 32'd0);
    end
    m_cap = m_cap | 32'h8;
    bus_read(3'd3, rd);
    check("lat_cap", rd, 32'h0000_0008);

    // W1C of the only masked bit drops irq one clock later
    @(negedge clk); address = 3'd3; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    check("w1c_irq_w", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("w1c_irq_w1", {31'd0, irq}, 32'd0);
    m_cap = m_cap & ~32'h8;

    // W1C on the same edge as a new capture keeps the bit
    set_ext(32'd0);
    set_ext(32'h8);
    set_ext(32'd0);
    check("same_pre_irq", {31'd0, irq}, 32'd1);
    @(negedge clk); ext_val[3] = 1'b1; m_ext[3] = 1'b1;
    for (int j = 0; j <= LAT; j++) @(negedge clk);
    address = 3'd3; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    check("same_irq_w", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("same_irq_w1", {31'd0, irq}, 32'd1);
    bus_read(3'd3, rd);
    check("same_cap", rd, 32'h0000_0008);

    // falling-edge polarity on pin 4
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'h0000_0010);
    set_ext(m_ext | 32'h10);
    bus_read(3'd3, rd);
    check("esel_rise", rd & 32'h10, 32'h0);
    set_ext(m_ext & ~32'h10);
    bus_read(3'd3, rd);
    check("esel_fall", rd & 32'h10, 32'h10);

`ifdef CRYPTO_WALLET_PIO_DEBOUNCE_EN
    // short glitch is filtered, long pulse passes
    bus_write(3'd6, 32'd0);
    bus_write(3'd3, 32'hFFFF_FFFF);
    @(negedge clk); ext_val[6] = 1'b1;
    repeat (5) @(negedge clk);
    ext_val[6] = 1'b0;
    settle();
    bus_read(3'd0, rd);
    check("deb_glitch_data", rd & 32'h40, 32'h0);
    bus_read(3'd3, rd);
    check("deb_glitch_cap", rd & 32'h40, 32'h0);
    set_ext(m_ext | 32'h40);
    bus_read(3'd0, rd);
    check("deb_stable_data", rd & 32'h40, 32'h40);
    bus_read(3'd3, rd);
    check("deb_stable_cap", rd & 32'h40, 32'h40);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) set_ext($urandom);
      else bus_write(3'($urandom_range(0, 7)), $urandom);
      check($sformatf("rnd%0d_irq", n), {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
      check($sformatf("rnd%0d_pins", n), bidir_port, eff());
      ra = rlist[$urandom_range(0, 5)];
      bus_read(ra, rd);
      check($sformatf("rnd%0d_rd%0d", n, ra), rd, model_read(ra));
    end
    for (int k = 0; k < 6; k++) begin
      bus_read(rlist[k], rd);
      check($sformatf("sweep_rd%0d", rlist[k]), rd, model_read(rlist[k]));
    end

    // reset in the middle of a write with irq active
    bus_write(3'd1, 32'd0);
    set_ext(32'd0);
    bus_write(3'd6, 32'd0);
    bus_write(3'd2, 32'h8);
    set_ext(32'h8);
    check("prerst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    address = 3'd1; writedata = 32'hFFFF; chipselect = 1'b1; write_n = 1'b0;
    #2;
    reset_n = 1'b0; ext_val = 32'd0; ext_en = 32'hFFFF_FFFF;
    #1;
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_pins", bidir_port, 32'd0);
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_dout = 32'd0; m_dir = 32'd0; m_mask = 32'd0; m_cap = 32'd0; m_sel = 32'd0; m_ext = 32'd0;
    settle();
    bus_read(3'd1, rd);
    check("postrst_dir", rd, 32'd0);
    bus_read(3'd3, rd);
    check("postrst_cap", rd, 32'd0);
    bus_read(3'd2, rd);
    check("postrst_mask", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
